// File: rtl/tff_ctrl_pkg.sv
// Shared types and constants for the T flip-flop counter controller.
package tff_ctrl_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } state_e;

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops: each bit toggles when its t input is high.
module tff_bank
    import tff_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                q[i] <= 1'b0;
            end else begin
                q[i] <= q[i] ^ t[i];
            end
        end
    end

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencer producing the toggle vector for a TFF counter bank: up/down, load,
// pause/resume and wrap or one-shot termination at a latched limit.
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic             wrap,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] t, cnt_t, term, restart;
    logic             at_term, carry;

    tff_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk  (clk),
        .reset(reset),
        .t    (t),
        .q    (q)
    );

    always_comb begin
        term    = dir_q ? lim_q : '0;
        restart = dir_q ? '0 : lim_q;
        at_term = (q == term);
        busy    = (state_q != StIdle);
        tc      = (state_q == StRun) && at_term;
        done    = done_q;
    end

    // Ripple-enable toggle chain: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        cnt_t = '0;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_t[i] = carry;
            carry    = carry & (dir_q ? q[i] : ~q[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        dir_d   = dir_q;
        wrap_d  = wrap_q;
        done_d  = 1'b0;
        t       = '0;
        if (load) begin
            t       = q ^ load_val;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!stop && start) begin
                        lim_d   = limit;
                        dir_d   = up_dn;
                        wrap_d  = wrap;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_d = StPause;
                    end else if (!at_term) begin
                        t = cnt_t;
                    end else if (wrap_q) begin
                        t = q ^ restart;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                StPause: begin
                    if (!stop && start) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            lim_q   <= '0;
            dir_q   <= 1'b1;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed scoreboard bench for tff_count_ctrl at WIDTH = 4.
module tb_tff_count_ctrl;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic         busy;
        logic         tc;
        logic         done;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0, stop = 1'b0, up_dn = 1'b1, wrap = 1'b0, load = 1'b0;
    logic [W-1:0] load_val = '0, limit = '0;
    logic [W-1:0] q;
    logic         busy, tc, done;

    exp_t sb[$];
    int   total  = 0;
    int   passes = 0;
    int   stepno = 0;

    tff_count_ctrl #(
        .WIDTH(W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .up_dn   (up_dn),
        .wrap    (wrap),
        .load    (load),
        .load_val(load_val),
        .limit   (limit),
        .q       (q),
        .busy    (busy),
        .tc      (tc),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s step %0d observed=%0h expected=%0h", tag, stepno, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] eq, input logic eb, input logic et, input logic ed);
        exp_t e;
        e.q = eq; e.busy = eb; e.tc = et; e.done = ed;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with the current outputs.
    task automatic sample();
        exp_t e;
        stepno++;
        total++;
        assert (sb.size() > 0) begin
            passes++;
        end else begin
            $error("FAIL scoreboard_empty step %0d observed=0 expected=1", stepno);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("q", 16'(q), 16'(e.q));
            chk("busy", 16'(busy), 16'(e.busy));
            chk("tc", 16'(tc), 16'(e.tc));
            chk("done", 16'(done), 16'(e.done));
        end
    endtask

    task automatic step(input logic [W-1:0] eq, input logic eb, input logic et, input logic ed);
        push(eq, eb, et, ed);
        @(posedge clk);
        #1;
        sample();
    endtask

    initial begin
        // Reset state, released between edges
        #12;
        push(4'd0, 1'b0, 1'b0, 1'b0);
        sample();
        reset = 1'b1;

        // 1: up one-shot to 5
        up_dn = 1'b1; wrap = 1'b0; limit = 4'd5; start = 1'b1;
        step(4'd0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        for (int i = 1; i <= 5; i++) step(W'(i), 1'b1, (i == 5), 1'b0);
        step(4'd5, 1'b0, 1'b0, 1'b1);
        step(4'd5, 1'b0, 1'b0, 1'b0);

        // 2: up wrap at 3
        load = 1'b1; load_val = 4'd0;
        step(4'd0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; up_dn = 1'b1; wrap = 1'b1; limit = 4'd3; start = 1'b1;
        step(4'd0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        for (int i = 1; i <= 8; i++) step(W'(i % 4), 1'b1, ((i % 4) == 3), 1'b0);

        // 3: load 9, down wrap from 9
        load = 1'b1; load_val = 4'd9;
        step(4'd9, 1'b0, 1'b0, 1'b0);
        load = 1'b0; up_dn = 1'b0; wrap = 1'b1; limit = 4'd9; start = 1'b1;
        step(4'd9, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        for (int i = 8; i >= 0; i--) step(W'(i), 1'b1, (i == 0), 1'b0);
        step(4'd9, 1'b1, 1'b0, 1'b0);
        step(4'd8, 1'b1, 1'b0, 1'b0);

        // 4: pause at 6, settings changed mid-run must be ignored
        load = 1'b1; load_val = 4'd0;
        step(4'd0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; up_dn = 1'b1; wrap = 1'b0; limit = 4'hF; start = 1'b1;
        step(4'd0, 1'b1, 1'b0, 1'b0);
        start = 1'b0; limit = 4'd2; up_dn = 1'b0;
        for (int i = 1; i <= 6; i++) step(W'(i), 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        step(4'd6, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        step(4'd6, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        step(4'd6, 1'b1, 1'b0, 1'b0);
        stop = 1'b0; start = 1'b1;
        step(4'd6, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        step(4'd7, 1'b1, 1'b0, 1'b0);
        step(4'd8, 1'b1, 1'b0, 1'b0);

        // 5: load 0xA during RUN at 3
        load = 1'b1; load_val = 4'd0;
        step(4'd0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; up_dn = 1'b1; wrap = 1'b0; limit = 4'hF; start = 1'b1;
        step(4'd0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        for (int i = 1; i <= 3; i++) step(W'(i), 1'b1, 1'b0, 1'b0);
        load = 1'b1; load_val = 4'hA;
        step(4'hA, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        step(4'hA, 1'b0, 1'b0, 1'b0);

        // 6: asynchronous reset mid-run at 0xC
        start = 1'b1;
        step(4'hA, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        step(4'hB, 1'b1, 1'b0, 1'b0);
        step(4'hC, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        push(4'd0, 1'b0, 1'b0, 1'b0);
        sample();
        step(4'd0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        step(4'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        step(4'd0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        step(4'd1, 1'b1, 1'b0, 1'b0);

        // Start already at term, one-shot: done next cycle, no count
        load = 1'b1; load_val = 4'd5;
        step(4'd5, 1'b0, 1'b0, 1'b0);
        load = 1'b0; up_dn = 1'b1; wrap = 1'b0; limit = 4'd5; start = 1'b1;
        step(4'd5, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        step(4'd5, 1'b0, 1'b0, 1'b1);

        // Up/wrap with limit 0: q parked at 0 with tc high
        load = 1'b1; load_val = 4'd0;
        step(4'd0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; up_dn = 1'b1; wrap = 1'b1; limit = 4'd0; start = 1'b1;
        step(4'd0, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        step(4'd0, 1'b1, 1'b1, 1'b0);
        step(4'd0, 1'b1, 1'b1, 1'b0);

        // Up with q above limit: passes 15, wraps to 0, stops at limit 1
        load = 1'b1; load_val = 4'hE;
        step(4'hE, 1'b0, 1'b0, 1'b0);
        load = 1'b0; up_dn = 1'b1; wrap = 1'b0; limit = 4'd1; start = 1'b1;
        step(4'hE, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        step(4'hF, 1'b1, 1'b0, 1'b0);
        step(4'h0, 1'b1, 1'b0, 1'b0);
        step(4'h1, 1'b1, 1'b1, 1'b0);
        step(4'h1, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
